jelly2_buffer_reader_sequencer: RTL
===================================

// Module: jelly2_buffer_reader_sequencer
// PURPOSE
//  Client-side sequencer for one reader port of the buffer manager/arbiter.
//  Per frame: request a buffer, capture its addr/index, launch one read DMA, wait for done, release.
//  Guarantees every granted buffer is released exactly once, so the manager's refcnt never leaks.
//  Sits between the buffer manager reader port and a read DMA or video-out engine.
// PARAMETERS
//  ADDR_WIDTH     32  buffer base address width; equals the manager's ADDR_WIDTH
//  INDEX_WIDTH    2   buffer index width; equals the manager's INDEX_WIDTH
//  SIZE_WIDTH     24  DMA transfer size width, in bytes
//  REQ_LATENCY    1   cycles from buffer_request to valid buffer_addr/index (range 1..7)
//  TIMEOUT_WIDTH  16  watchdog counter width; used only with the macro below
// PORTS
//  clk              in   1            clock
//  reset            in   1            synchronous reset, active-high
//  cke              in   1            clock enable; when low, all state and outputs hold
//  enable           in   1            run frames continuously while high
//  oneshot          in   1            when high, run one frame and then stop
//  param_size       in   SIZE_WIDTH   transfer size; sampled in REQ
//  param_timeout    in   TIMEOUT_WIDTH watchdog limit in cycles
//  busy             out  1            high in any state other than IDLE
//  buffer_request   out  1            1-cycle pulse to the manager reader_request
//  buffer_release   out  1            1-cycle pulse to the manager reader_release
//  buffer_addr      in   ADDR_WIDTH   from the manager reader_addr
//  buffer_index     in   INDEX_WIDTH  from the manager reader_index
//  dma_valid        out  1            DMA start command valid
//  dma_ready        in   1            DMA start command accept
//  dma_addr         out  ADDR_WIDTH   captured buffer address
//  dma_size         out  SIZE_WIDTH   captured param_size
//  dma_done         in   1            1-cycle DMA completion pulse
//  current_index    out  INDEX_WIDTH  index of the buffer currently held
//  frame_count      out  16           completed frames; wraps 0xFFFF -> 0
//  error_timeout    out  1            sticky watchdog flag; cleared by reset only
// BEHAVIOUR
//  Reset: state IDLE; every output 0.
//  FSM transitions (each advances only when cke=1):
//   - IDLE->REQ when enable|oneshot.
//   - REQ: buffer_request=1 for 1 cycle; latch param_size; ->WAIT.
//   - WAIT: count REQ_LATENCY cycles; on the last, latch buffer_addr/index into dma_addr/current_index.
//     Then ->START if size!=0; ->REL if size==0, with no DMA issued.
//   - START: dma_valid held high until dma_valid&dma_ready; addr/size stable while valid; ->RUN.
//   - RUN: wait for dma_done; ->REL.
//     dma_done in the same cycle as the START handshake counts as done (go straight to REL).
//     dma_done in any other state is ignored.
//   - REL: buffer_release=1 for 1 cycle; frame_count+1.
//     Then ->REQ if enable & ~oneshot_latched, else ->IDLE.
//  oneshot: latched in IDLE; the run stops after that one frame even if enable is high.
//  enable dropping mid-frame: the frame completes and releases, then ->IDLE. No abort path.
//  Reset mid-frame: immediate return to IDLE with no release pulse; the manager shares this reset.
//  request and release are never high in the same cycle. At most one buffer is held at a time.
// CONFIGURATION
//  JELLY2_BUFFER_READER_SEQUENCER_TIMEOUT_EN defined:
//   - A watchdog counts cycles in START/RUN and resets on entry to START.
//   - When count==param_timeout (and param_timeout!=0): set error_timeout, drop dma_valid, ->REL.
//     The buffer is still released.
//  Undefined: no counter; error_timeout tied 0; param_timeout ignored.
// STRUCTURE
//  Package jelly2_buffer_reader_pkg holds:
//   - state_t enum {IDLE,REQ,WAIT,START,RUN,REL}
//   - localparam FRAME_COUNT_WIDTH=16
//  Sub-module jelly2_buffer_reader_watchdog: counter plus compare, instantiated only under the macro.
//  Everything else is one always_ff FSM plus registered outputs.
// TESTING
//  Bench: manager model with addr=0x1000_0000+idx*0x10_0000 and REQ_LATENCY=1. Required results:
//  1. oneshot, size=0x100, ready=1, done 5 cycles after accept:
//     1 request, dma_addr=manager addr, 1 release, frame_count=1, busy falls after REL.
//  2. enable held 3 frames, then dropped during the 3rd RUN:
//     3rd frame completes and releases, frame_count=3, IDLE, #request==#release.
//  3. ready low 10 cycles: dma_valid/addr/size stable throughout; done on the accept cycle
//     -> REL on the next cycle.
//  4. param_size=0: request then release with no dma_valid; frame_count increments.
//  5. Reset asserted in RUN: next cycle all outputs 0, no release pulse.
//     cke=0 for 4 cycles mid-START: all state held.
//  6. Timeout macro on, param_timeout=20, no done: error_timeout=1 at cycle 20 of the watchdog.
//     Release issued; next frame proceeds.

Source files
------------

// File: rtl/jelly2_buffer_reader_pkg.sv
// Shared types for the buffer reader sequencer: FSM state encoding and frame counter width.
package jelly2_buffer_reader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        START = 3'd3,
        RUN   = 3'd4,
        REL   = 3'd5
    } state_t;

    localparam int FRAME_COUNT_WIDTH = 16;

endpackage

// File: rtl/jelly2_buffer_reader_watchdog.sv
// Cycle counter for the START/RUN phase; expired is high on the cycle the count reaches limit.
module jelly2_buffer_reader_watchdog
    import jelly2_buffer_reader_pkg::*;
    #(
        parameter int TIMEOUT_WIDTH = 16
    )
    (
        input  logic                      clk,
        input  logic                      reset,
        input  logic                      cke,
        input  logic                      clear,
        input  logic                      run,
        input  logic [TIMEOUT_WIDTH-1:0]  limit,
        output logic                      expired
    );

    logic [TIMEOUT_WIDTH-1:0] count;

    // count equals the 1-based index of the current START/RUN cycle; saturates instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end
        else if (cke) begin
            if (clear) begin
                count <= TIMEOUT_WIDTH'(1);
            end
            else if (run && count != '1) begin
                count <= count + 1'b1;
            end
        end
    end

    assign expired = run && (limit != '0) && (count == limit);

endmodule

// File: rtl/jelly2_buffer_reader_sequencer.sv
// Reader-port sequencer: request buffer, launch one read DMA, wait for done, release.
// Optional watchdog enabled by defining JELLY2_BUFFER_READER_SEQUENCER_TIMEOUT_EN.
module jelly2_buffer_reader_sequencer
    import jelly2_buffer_reader_pkg::*;
    #(
        parameter int ADDR_WIDTH    = 32,
        parameter int INDEX_WIDTH   = 2,
        parameter int SIZE_WIDTH    = 24,
        parameter int REQ_LATENCY   = 1,
        parameter int TIMEOUT_WIDTH = 16
    )
    (
        input  logic                          clk,
        input  logic                          reset,
        input  logic                          cke,

        input  logic                          enable,
        input  logic                          oneshot,
        input  logic [SIZE_WIDTH-1:0]         param_size,
        input  logic [TIMEOUT_WIDTH-1:0]      param_timeout,
        output logic                          busy,

        output logic                          buffer_request,
        output logic                          buffer_release,
        input  logic [ADDR_WIDTH-1:0]         buffer_addr,
        input  logic [INDEX_WIDTH-1:0]        buffer_index,

        output logic                          dma_valid,
        input  logic                          dma_ready,
        output logic [ADDR_WIDTH-1:0]         dma_addr,
        output logic [SIZE_WIDTH-1:0]         dma_size,
        input  logic                          dma_done,

        output logic [INDEX_WIDTH-1:0]        current_index,
        output logic [FRAME_COUNT_WIDTH-1:0]  frame_count,
        output logic                          error_timeout
    );

    state_t      state;
    logic        oneshot_latched;
    logic [2:0]  lat_cnt;
    logic        lat_last;
    logic        timeout;

    assign lat_last = (lat_cnt == 3'(REQ_LATENCY - 1));

`ifdef JELLY2_BUFFER_READER_SEQUENCER_TIMEOUT_EN
    logic wd_clear;
    logic wd_run;
    logic error_flag;

    assign wd_clear = (state == WAIT) && lat_last && (dma_size != '0);
    assign wd_run   = (state == START) || (state == RUN);

    jelly2_buffer_reader_watchdog
        #(
            .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
        )
        u_watchdog
        (
            .clk            (clk),
            .reset          (reset),
            .cke            (cke),
            .clear          (wd_clear),
            .run            (wd_run),
            .limit          (param_timeout),
            .expired        (timeout)
        );

    always_ff @(posedge clk) begin
        if (reset) begin
            error_flag <= 1'b0;
        end
        else if (cke && timeout) begin
            error_flag <= 1'b1;
        end
    end

    assign error_timeout = error_flag;
`else
    logic unused_timeout;
    assign unused_timeout = ^param_timeout;
    assign timeout        = 1'b0;
    assign error_timeout  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            oneshot_latched <= 1'b0;
            lat_cnt         <= '0;
            dma_addr        <= '0;
            dma_size        <= '0;
            current_index   <= '0;
            frame_count     <= '0;
        end
        else if (cke) begin
            case (state)
                IDLE: begin
                    if (enable || oneshot) begin
                        oneshot_latched <= oneshot;
                        state           <= REQ;
                    end
                end

                REQ: begin
                    dma_size <= param_size;
                    lat_cnt  <= '0;
                    state    <= WAIT;
                end

                WAIT: begin
                    if (lat_last) begin
                        dma_addr      <= buffer_addr;
                        current_index <= buffer_index;
                        state         <= (dma_size != '0) ? START : REL;
                    end
                    else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end

                // a done coinciding with the accept means the transfer already finished
                START: begin
                    if (timeout) begin
                        state <= REL;
                    end
                    else if (dma_ready) begin
                        state <= dma_done ? REL : RUN;
                    end
                end

                RUN: begin
                    if (timeout || dma_done) begin
                        state <= REL;
                    end
                end

                REL: begin
                    frame_count <= frame_count + 1'b1;
                    state       <= (enable && !oneshot_latched) ? REQ : IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy           = (state != IDLE);
    assign buffer_request = (state == REQ);
    assign buffer_release = (state == REL);
    assign dma_valid      = (state == START) && !timeout;

endmodule
